// File: rtl/servant_mem_arbiter.sv
// servant_mem_arbiter: round-robin Wishbone arbiter of three masters onto the servant RAM, with bus-timeout watchdog
module servant_mem_arbiter #(
  parameter int AW = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  input  logic [AW-1:0] i_m0_wb_adr,
  input  logic [31:0]   i_m0_wb_dat,
  input  logic [3:0]    i_m0_wb_sel,
  input  logic          i_m0_wb_we,
  input  logic          i_m0_wb_cyc,
  output logic          o_m0_wb_ack,
  output logic          o_m0_wb_err,
  output logic [31:0]   o_m0_wb_rdt,
  input  logic [AW-1:0] i_m1_wb_adr,
  input  logic [31:0]   i_m1_wb_dat,
  input  logic [3:0]    i_m1_wb_sel,
  input  logic          i_m1_wb_we,
  input  logic          i_m1_wb_cyc,
  output logic          o_m1_wb_ack,
  output logic          o_m1_wb_err,
  output logic [31:0]   o_m1_wb_rdt,
  input  logic [AW-1:0] i_m2_wb_adr,
  input  logic [31:0]   i_m2_wb_dat,
  input  logic [3:0]    i_m2_wb_sel,
  input  logic          i_m2_wb_we,
  input  logic          i_m2_wb_cyc,
  output logic          o_m2_wb_ack,
  output logic          o_m2_wb_err,
  output logic [31:0]   o_m2_wb_rdt,
  output logic [AW-1:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic          i_wb_ack,
  input  logic [31:0]   i_wb_rdt,
  output logic [1:0]    o_grant,
  output logic          o_timeout
);
  localparam int TB = $clog2(TIMEOUT + 1);
  localparam int CW = TB < 8 ? 8 : (TB > 32 ? 32 : TB);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic [1:0] grant, grant_nxt, last, last_nxt, s0, s1, s2, winner;
  logic [CW-1:0] cnt;
  logic [2:0] cyc_v;
  logic busy, cyc_g, expire, ack_g, err_g;
  logic [AW-1:0] adr_m, adr_h;
  logic [31:0] dat_m, dat_h;
  logic [3:0] sel_m, sel_h;
  logic we_m, we_h;
  assign cyc_v = {i_m2_wb_cyc, i_m1_wb_cyc, i_m0_wb_cyc};
  assign busy = state == BUSY;
  // search order starts just after the most recently granted master
  assign s0 = last == 2'd2 ? 2'd0 : last + 2'd1;
  assign s1 = s0 == 2'd2 ? 2'd0 : s0 + 2'd1;
  assign s2 = s1 == 2'd2 ? 2'd0 : s1 + 2'd1;
  assign winner = cyc_v[s0] ? s0 : cyc_v[s1] ? s1 : s2;
  assign adr_m = grant == 2'd0 ? i_m0_wb_adr : grant == 2'd1 ? i_m1_wb_adr : i_m2_wb_adr;
  assign dat_m = grant == 2'd0 ? i_m0_wb_dat : grant == 2'd1 ? i_m1_wb_dat : i_m2_wb_dat;
  assign sel_m = grant == 2'd0 ? i_m0_wb_sel : grant == 2'd1 ? i_m1_wb_sel : i_m2_wb_sel;
  assign we_m  = grant == 2'd0 ? i_m0_wb_we  : grant == 2'd1 ? i_m1_wb_we  : i_m2_wb_we;
  assign cyc_g = grant == 2'd0 ? i_m0_wb_cyc : grant == 2'd1 ? i_m1_wb_cyc : grant == 2'd2 && i_m2_wb_cyc;
  assign expire = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
  // a master that already dropped cyc, or a reset cycle, sees neither ack nor err
  assign ack_g = busy && i_wb_ack && cyc_g && !i_wb_rst;
  assign err_g = busy && expire && !i_wb_ack && cyc_g && !i_wb_rst;
  assign o_m0_wb_ack = ack_g && grant == 2'd0;
  assign o_m1_wb_ack = ack_g && grant == 2'd1;
  assign o_m2_wb_ack = ack_g && grant == 2'd2;
  assign o_m0_wb_err = err_g && grant == 2'd0;
  assign o_m1_wb_err = err_g && grant == 2'd1;
  assign o_m2_wb_err = err_g && grant == 2'd2;
  assign o_m0_wb_rdt = i_wb_rdt;
  assign o_m1_wb_rdt = i_wb_rdt;
  assign o_m2_wb_rdt = i_wb_rdt;
  assign o_wb_cyc = busy;
  assign o_wb_adr = busy ? adr_m : adr_h;
  assign o_wb_dat = busy ? dat_m : dat_h;
  assign o_wb_sel = busy ? sel_m : sel_h;
  assign o_wb_we  = busy ? we_m  : we_h;
  assign o_grant = grant;
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt = last;
    if (!busy && |cyc_v) begin
      state_nxt = BUSY;
      grant_nxt = winner;
      last_nxt = winner;
    end
    if (busy && (i_wb_ack || !cyc_g || expire)) begin
      state_nxt = IDLE;
      grant_nxt = 2'd3;
    end
  end
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state <= IDLE;
      grant <= 2'd3;
      last <= 2'd2;
      cnt <= '0;
      o_timeout <= 1'b0;
      adr_h <= '0;
      dat_h <= '0;
      sel_h <= '0;
      we_h <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last <= last_nxt;
      cnt <= busy ? cnt + 1'b1 : '0;
      if (err_g) o_timeout <= 1'b1;
      if (busy) begin
        adr_h <= adr_m;
        dat_h <= dat_m;
        sel_h <= sel_m;
        we_h <= we_m;
      end
    end
  end
endmodule

// File: tb/tb_servant_mem_arbiter.sv
// tb_servant_mem_arbiter: randomized and directed bench against a transaction-level arbiter model
module tb_servant_mem_arbiter;
  localparam int TO = 4;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic mcyc[3], mwe[3];
  logic [31:0] madr[3], mdat[3], rdt[3];
  logic [3:0] msel[3];
  logic [2:0] ack, err;
  logic [31:0] wadr, wdat, srdt;
  logic [3:0] wsel;
  logic wwe, wcyc, sack, to;
  logic [1:0] gnt;
  servant_mem_arbiter #(.AW(32), .TIMEOUT(TO)) dut (
    .i_wb_clk(clk), .i_wb_rst(rst),
    .i_m0_wb_adr(madr[0]), .i_m0_wb_dat(mdat[0]), .i_m0_wb_sel(msel[0]), .i_m0_wb_we(mwe[0]), .i_m0_wb_cyc(mcyc[0]),
    .o_m0_wb_ack(ack[0]), .o_m0_wb_err(err[0]), .o_m0_wb_rdt(rdt[0]),
    .i_m1_wb_adr(madr[1]), .i_m1_wb_dat(mdat[1]), .i_m1_wb_sel(msel[1]), .i_m1_wb_we(mwe[1]), .i_m1_wb_cyc(mcyc[1]),
    .o_m1_wb_ack(ack[1]), .o_m1_wb_err(err[1]), .o_m1_wb_rdt(rdt[1]),
    .i_m2_wb_adr(madr[2]), .i_m2_wb_dat(mdat[2]), .i_m2_wb_sel(msel[2]), .i_m2_wb_we(mwe[2]), .i_m2_wb_cyc(mcyc[2]),
    .o_m2_wb_ack(ack[2]), .o_m2_wb_err(err[2]), .o_m2_wb_rdt(rdt[2]),
    .o_wb_adr(wadr), .o_wb_dat(wdat), .o_wb_sel(wsel), .o_wb_we(wwe), .o_wb_cyc(wcyc),
    .i_wb_ack(sack), .i_wb_rdt(srdt), .o_grant(gnt), .o_timeout(to)
  );
  int checks = 0, passed = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask
  bit m_busy = 0, m_to = 0, rnd = 0;
  int m_g = 3, m_last = 2, m_cnt = 0, lat = 1, lat_mode = 1, cyc_no = 0;
  logic [31:0] h_adr = 0, h_dat = 0;
  logic [3:0] h_sel = 0;
  logic h_we = 0;
  bit want[3];
  int gq[$], gt[$];
  logic [1:0] prev_gnt = 3, s_gnt;
  logic [2:0] s_ack, s_err;
  logic s_cyc, s_to;
  logic [31:0] s_adr, s_dat;
  function automatic int pick_lat();
    int opts[6] = '{0, 1, 1, 2, 3, 9};
    return lat_mode >= 0 ? lat_mode : opts[$urandom % 6];
  endfunction
  task automatic cycle();
    logic [2:0] eack = '0, eerr = '0;
    sack = m_busy && m_cnt == lat;
    srdt = $urandom;
    if (m_busy && mcyc[m_g] && !rst) begin
      eack[m_g] = sack;
      eerr[m_g] = !sack && m_cnt == TO - 1;
    end
    @(negedge clk);
    chk("cyc", wcyc, m_busy);
    chk("grant", gnt, m_busy ? m_g : 3);
    chk("adr", wadr, m_busy ? madr[m_g] : h_adr);
    chk("dat", wdat, m_busy ? mdat[m_g] : h_dat);
    chk("sel", wsel, m_busy ? msel[m_g] : h_sel);
    chk("we", wwe, m_busy ? mwe[m_g] : h_we);
    chk("ack", ack, eack);
    chk("err", err, eerr);
    chk("timeout", to, m_to);
    chk("rdt", rdt[cyc_no % 3], srdt);
    {s_cyc, s_gnt, s_ack, s_err, s_to, s_adr, s_dat} = {wcyc, gnt, ack, err, to, wadr, wdat};
    if (gnt != 3 && prev_gnt == 3) begin
      gq.push_back(gnt);
      gt.push_back(cyc_no);
    end
    prev_gnt = gnt;
    @(posedge clk);
    #1;
    if (rst) begin
      {m_busy, m_to, m_cnt, m_g, m_last} = {1'b0, 1'b0, 32'd0, 32'd3, 32'd2};
      {h_adr, h_dat, h_sel, h_we} = '0;
    end else if (!m_busy) begin
      for (int k = 1; k <= 3; k++)
        if (!m_busy && mcyc[(m_last + k) % 3]) begin
          m_busy = 1;
          m_g = (m_last + k) % 3;
          m_last = m_g;
          m_cnt = 0;
          lat = pick_lat();
        end
    end else begin
      {h_adr, h_dat, h_sel, h_we} = {madr[m_g], mdat[m_g], msel[m_g], mwe[m_g]};
      if (eerr != 0) m_to = 1;
      if (sack || !mcyc[m_g] || m_cnt == TO - 1) begin
        m_busy = 0;
        m_g = 3;
      end else m_cnt++;
    end
    for (int k = 0; k < 3; k++) begin
      if (!mcyc[k] && want[k] && (!rnd || $urandom % 4 == 0)) begin
        mcyc[k] = 1;
        madr[k] = $urandom;
        msel[k] = 4'($urandom);
        mdat[k] = k == 0 ? 0 : $urandom;
        mwe[k] = k == 0 ? 0 : 1'($urandom);
      end else if (mcyc[k] && rnd && $urandom % 40 == 0) mcyc[k] = 0;
      if (eack[k] || eerr[k]) mcyc[k] = 0;
    end
    cyc_no++;
  endtask
  task automatic drain();
    want = '{0, 0, 0};
    repeat (12) cycle();
    gq.delete();
    gt.delete();
  endtask
  initial begin
    bit ack_seen, err_seen;
    int ec;
    for (int k = 0; k < 3; k++) {mcyc[k], mwe[k], madr[k], mdat[k], msel[k]} = '0;
    want = '{0, 0, 0};
    sack = 0;
    srdt = 0;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    rst = 0;
    mcyc[1] = 1; madr[1] = 32'h100; mdat[1] = 32'hDEADBEEF; msel[1] = 4'hF; mwe[1] = 1;
    cycle();
    chk("w0_cyc", s_cyc, 0);
    cycle();
    chk("w1_cyc", s_cyc, 1);
    chk("w1_adr", s_adr, 32'h100);
    chk("w1_dat", s_dat, 32'hDEADBEEF);
    chk("w1_ack", s_ack, 0);
    cycle();
    chk("w2_ack", s_ack, 3'b010);
    cycle();
    chk("w3_grant", s_gnt, 3);
    chk("w3_ack", s_ack, 0);
    rst = 1;
    want = '{1, 1, 1};
    cycle();
    rst = 0;
    gq.delete();
    gt.delete();
    repeat (20) cycle();
    chk("rr_count", gq.size() >= 6, 1);
    for (int i = 0; i < 6; i++) chk("rr_order", i < gq.size() ? gq[i] : 3, i % 3);
    for (int i = 1; i < gt.size(); i++) chk("rr_gap", gt[i] - gt[i-1], 3);
    drain();
    want = '{0, 1, 1};
    repeat (20) cycle();
    chk("alt_count", gq.size() >= 5, 1);
    for (int i = 1; i < gq.size(); i++) begin
      chk("alt_order", gq[i] + gq[i-1], 3);
      chk("alt_gap", gt[i] - gt[i-1], 3);
    end
    drain();
    lat_mode = 9;
    mcyc[2] = 1; madr[2] = 32'h2000; mdat[2] = 32'h55; msel[2] = 4'h3; mwe[2] = 1;
    ec = -1;
    for (int i = 0; i < 10 && ec < 0; i++) begin
      cycle();
      if (s_err[2]) ec = cyc_no - 1;
    end
    chk("to_seen", ec >= 0, 1);
    chk("to_cycle", gt.size() > 0 ? ec - gt[0] + 1 : 0, 4);
    cycle();
    chk("to_flag", s_to, 1);
    lat_mode = 1;
    mcyc[0] = 1; madr[0] = 32'h40; msel[0] = 4'hF;
    repeat (4) cycle();
    chk("to_sticky", s_to, 1);
    chk("to_next_grant", gq.size() > 1 ? gq[1] : 3, 0);
    drain();
    lat_mode = 3;
    mcyc[0] = 1; madr[0] = 32'h80;
    ack_seen = 0;
    err_seen = 0;
    repeat (6) begin
      cycle();
      ack_seen |= s_ack[0];
      err_seen |= |s_err;
    end
    chk("tie_ack", ack_seen, 1);
    chk("tie_err", err_seen, 0);
    chk("tie_to", s_to, 1);
    lat_mode = 9;
    mcyc[1] = 1; madr[1] = 32'h300;
    repeat (2) cycle();
    chk("rst_busy", s_cyc, 1);
    rst = 1;
    cycle();
    rst = 0;
    cycle();
    chk("rst_cyc", s_cyc, 0);
    chk("rst_grant", s_gnt, 3);
    chk("rst_to", s_to, 0);
    drain();
    lat_mode = -1;
    rnd = 1;
    want = '{1, 1, 1};
    repeat (1500) cycle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/servant_mem_arbiter.md
# servant_mem_arbiter

Round-robin Wishbone arbiter sharing the servant single-port RAM between three masters: SERV instruction bus (m0), SERV data bus (m1) and the SPI/I2C peripheral DMA port (m2). It sits between the CPU/peripheral buses and the RAM slave, and holds each grant for one complete transaction. A bus-timeout watchdog returns an error to the granted master if the slave never acknowledges.

## Interface
Parameters:
- AW, 32, address width of all master and slave ports.
- TIMEOUT, 255, cycles in BUSY without ack before abort; 0 disables the watchdog.

Ports:
- i_wb_clk  input  1  single clock; all state changes on its rising edge.
- i_wb_rst  input  1  synchronous, active-high reset.
- i_mN_wb_adr  input  AW  master N address (N = 0, 1, 2).
- i_mN_wb_dat  input  32  master N write data (m0: tie 0).
- i_mN_wb_sel  input  4  master N byte enables.
- i_mN_wb_we  input  1  master N write enable (m0: tie 0).
- i_mN_wb_cyc  input  1  master N request; held high until ack or err.
- o_mN_wb_ack  output  1  master N acknowledge.
- o_mN_wb_err  output  1  master N timeout error, one-cycle pulse.
- o_mN_wb_rdt  output  32  read data, o_wb_rdt broadcast unregistered to all masters.
- o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc  output  AW/32/4/1/1  slave port to RAM.
- i_wb_ack  input  1  slave acknowledge.
- i_wb_rdt  input  32  slave read data.
- o_grant  output  2  granted master index; 3 = none.
- o_timeout  output  1  sticky flag, set on any watchdog abort.

## Operation
- States: IDLE, BUSY.
- IDLE: if any i_mN_wb_cyc is high, select the winner, register grant = winner, and go to BUSY. Otherwise stay in IDLE.
- Round-robin selection: search starts at index (last + 1) mod 3. last is the most recently granted index; reset value 2, so m0 has first priority.
- BUSY: o_wb_cyc = 1. adr, dat, sel and we are muxed combinationally from the granted master. o_mG_wb_ack = i_wb_ack, and the acks of non-granted masters are 0.
- BUSY exits to IDLE with grant = 3 on the edge after any one of the following:
  - i_wb_ack high (normal completion);
  - the granted master's cyc low (master abort; no ack is forwarded);
  - watchdog expiry.
- Watchdog: an 8..32-bit counter, sized from TIMEOUT, clears on entry to BUSY and increments each BUSY cycle. When it equals TIMEOUT-1 with no ack, o_mG_wb_err pulses for that cycle and o_timeout is set.
- Simultaneous ack and expiry: ack wins; no err is raised and o_timeout is unchanged.
- o_timeout is cleared only by i_wb_rst.
- A master's cyc dropping while that master is not granted has no effect.

## Timing
- Reset values:
  - state IDLE, grant 3, last 2;
  - o_wb_cyc, o_wb_we 0; o_wb_adr, o_wb_dat, o_wb_sel 0;
  - all acks 0, all errs 0, o_timeout 0.
- Reset mid-transaction drops o_wb_cyc on the next edge. The ack is not forwarded in the reset cycle.
- Latency: request seen in cycle 0; o_wb_cyc high in cycle 1. With the 1-cycle servant RAM, ack arrives in cycle 2 and o_wb_cyc is low in cycle 3.
- The mandatory IDLE cycle lets SERV drop cyc after its ack. The next grant is therefore registered no earlier than cycle 4.
- Slave outputs while IDLE: o_wb_cyc = 0. Address, data, sel and we hold the value driven in the last BUSY cycle.
- Sustained throughput: one transaction per 3 cycles with a 1-cycle slave.

## Test plan
- Single m1 write: adr 0x100, dat 0xDEADBEEF, sel 0xF, we 1. Required: o_wb_cyc high in cycle 1 with those values; o_m1_wb_ack high in cycle 2 only; grant returns to 3 in cycle 3.
- All three masters request from reset, each held until ack. Required: grant order m0, m1, m2, m0 …; each master's ack arrives on its own grant only; no master is granted twice while another waits.
- m1 and m2 request continuously. Required: grants alternate m1, m2, m1, m2; the inter-grant gap is exactly one IDLE cycle.
- TIMEOUT = 4 and the slave never acks m2. Required: o_m2_wb_err pulses in BUSY cycle 4; o_timeout = 1 and stays 1; the next request is granted normally.
- i_wb_ack and watchdog expiry in the same cycle. Required: ack only, no err, o_timeout unchanged. Then assert i_wb_rst during BUSY. Required: o_wb_cyc = 0, grant = 3 and o_timeout = 0 on the next edge.
